// File: rtl/gtxe2_comm_qpll_lockdet.sv
// QPLL lock detector / reference-clock monitor.
// Counts synchronized refclk edges per window and sequences VCO reset and lock.
`timescale 1ns/1ps
module gtxe2_comm_qpll_lockdet #(
    parameter int WINDOW       = 256,
    parameter int EXP_EDGES    = 64,
    parameter int TOLERANCE    = 2,
    parameter int LOCK_WINDOWS = 3,
    parameter int RESET_HOLD   = 8
) (
    input  logic        QPLLLOCKDETCLK,
    input  logic        QPLLRESET_N,
    input  logic [2:0]  QPLLREFCLKSEL,
    input  logic        QPLL_MUX_CLK_OUT,
    input  logic        QPLLLOCKEN,
    input  logic        QPLLPD,
    output logic        QPLLLOCK,
    output logic        QPLLREFCLKLOST,
    output logic        VCO_RESET,
    output logic [15:0] EDGE_COUNT
);

    localparam int WW = $clog2(WINDOW);
    localparam int GW = $clog2(LOCK_WINDOWS + 1);
    localparam int HW = $clog2(RESET_HOLD + 1);
    localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
    localparam logic [GW-1:0] G_LOCK = GW'(LOCK_WINDOWS);
    localparam logic [HW-1:0] H_LAST = HW'(RESET_HOLD - 1);
    localparam logic [15:0]   EXP    = 16'(EXP_EDGES);
    localparam logic [15:0]   TOL    = 16'(TOLERANCE);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        MEASURE,
        LOCKED
    } state_t;

    state_t         state;
    logic [2:0]     sel_q;
    logic           s1, s2, s3;
    logic [WW-1:0]  wcnt;
    logic [15:0]    ecnt;
    logic [GW-1:0]  gcnt;
    logic [HW-1:0]  hcnt;

    logic           edge_det;
    logic [16:0]    sum;
    logic [15:0]    fin_cnt;
    logic [15:0]    diff;
    logic           good;
    logic           win_end;
    logic [GW-1:0]  gnext;

    // the refclk is fully asynchronous to the detector clock
    always_ff @(posedge QPLLLOCKDETCLK or negedge QPLLRESET_N) begin
        if (!QPLLRESET_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= QPLL_MUX_CLK_OUT;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        edge_det = s2 & ~s3;
        sum      = {1'b0, ecnt} + 17'(edge_det);
        fin_cnt  = sum[16] ? 16'hFFFF : sum[15:0];
        diff     = (fin_cnt >= EXP) ? (fin_cnt - EXP) : (EXP - fin_cnt);
        good     = (diff <= TOL);
        win_end  = (wcnt == W_LAST);
        gnext    = gcnt + GW'(1);
    end

    always_ff @(posedge QPLLLOCKDETCLK or negedge QPLLRESET_N) begin
        if (!QPLLRESET_N) begin
            state          <= IDLE;
            sel_q          <= 3'd0;
            wcnt           <= '0;
            ecnt           <= '0;
            gcnt           <= '0;
            hcnt           <= '0;
            QPLLLOCK       <= 1'b0;
            QPLLREFCLKLOST <= 1'b0;
            VCO_RESET      <= 1'b0;
            EDGE_COUNT     <= 16'd0;
        end else if (QPLLPD || !QPLLLOCKEN) begin
            state     <= IDLE;
            sel_q     <= QPLLREFCLKSEL;
            QPLLLOCK  <= 1'b0;
            VCO_RESET <= 1'b0;
        end else if (state == IDLE || QPLLREFCLKSEL != sel_q) begin
            // (re)start: also discards any window ending this cycle
            state          <= HOLD;
            sel_q          <= QPLLREFCLKSEL;
            wcnt           <= '0;
            ecnt           <= '0;
            gcnt           <= '0;
            hcnt           <= '0;
            QPLLLOCK       <= 1'b0;
            QPLLREFCLKLOST <= 1'b0;
            VCO_RESET      <= 1'b1;
        end else begin
            unique case (state)
                HOLD: begin
                    hcnt <= hcnt + HW'(1);
                    if (hcnt == H_LAST) begin
                        state     <= MEASURE;
                        VCO_RESET <= 1'b0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (win_end) begin
                        wcnt           <= '0;
                        ecnt           <= '0;
                        EDGE_COUNT     <= fin_cnt;
                        QPLLREFCLKLOST <= (fin_cnt == 16'd0);
                        if (!good) begin
                            gcnt     <= '0;
                            state    <= MEASURE;
                            QPLLLOCK <= 1'b0;
                        end else if (state == MEASURE) begin
                            gcnt <= gnext;
                            if (gnext == G_LOCK) begin
                                state    <= LOCKED;
                                QPLLLOCK <= 1'b1;
                            end
                        end
                    end else begin
                        wcnt <= wcnt + WW'(1);
                        ecnt <= fin_cnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gtxe2_comm_qpll_lockdet.sv
// Directed bench for the QPLL lock detector.
// Covers lock-up, refclk loss, frequency limits, select change, PD/LOCKEN and reset.
`timescale 1ns/1ps
module tb_gtxe2_comm_qpll_lockdet;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  sel = 3'b001;
    logic        refclk = 1'b0;
    logic        locken = 1'b1;
    logic        pd = 1'b0;
    logic        lock;
    logic        lost;
    logic        vco;
    logic [15:0] ec;

    real ref_half = 20.0;
    bit  ref_en = 1'b1;

    int total = 0;
    int bad = 0;

    gtxe2_comm_qpll_lockdet dut (
        .QPLLLOCKDETCLK   (clk),
        .QPLLRESET_N      (rst_n),
        .QPLLREFCLKSEL    (sel),
        .QPLL_MUX_CLK_OUT (refclk),
        .QPLLLOCKEN       (locken),
        .QPLLPD           (pd),
        .QPLLLOCK         (lock),
        .QPLLREFCLKLOST   (lost),
        .VCO_RESET        (vco),
        .EDGE_COUNT       (ec)
    );

    always #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            if (ref_en) begin
                #(ref_half);
                if (ref_en) refclk = ~refclk;
            end else begin
                refclk = 1'b0;
                #1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs,
                           input logic [31:0] lo, input logic [31:0] hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_lock(output int n, output int vh,
                             output logic l1, output logic v1);
        n = -1;
        vh = 0;
        l1 = 1'bx;
        v1 = 1'bx;
        for (int i = 1; i <= 1200; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                l1 = lock;
                v1 = vco;
            end
            if (vco) vh++;
            if (lock) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_sig(input int which, input logic val,
                            input int lim, output int n);
        n = -1;
        for (int i = 0; i <= lim; i++) begin
            if ((which == 0 ? lock : lost) === val) begin
                n = i;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   n;
        int   vh;
        logic l1;
        logic v1;
        logic [15:0] saved;
        bit   seen;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_lock", lock, 0);
        chk("rst_lost", lost, 0);
        chk("rst_vco", vco, 0);
        chk("rst_ec", ec, 0);

        // first lock at 40ns refclk
        rst_n = 1'b1;
        wait_lock(n, vh, l1, v1);
        chk("lock1_cyc", n, 777);
        chk("lock1_vco_hold", vh, 8);
        chk("lock1_ec", ec, 64);
        chk("lock1_lost", lost, 0);
        chk("lock1_vco", vco, 0);

        // refclk stops while locked
        ref_en = 1'b0;
        wait_sig(0, 1'b0, 300, n);
        chk("stop_drop_cyc", n, 256);
        chk_rng("stop_partial_ec", ec, 0, 2);
        wait_sig(1, 1'b1, 300, n);
        chk("stop_lost", lost, 1);
        chk("stop_ec0", ec, 0);
        chk("stop_lock", lock, 0);

        // refclk restarts right after a window end
        ref_en = 1'b1;
        @(posedge clk);
        #1;
        wait_sig(1, 1'b0, 300, n);
        chk("restart_lost_clr", n, 255);
        wait_sig(0, 1'b1, 600, n);
        chk("restart_relock", n, 512);
        chk("restart_ec", ec, 64);

        // 36ns refclk: too many edges, never locks
        @(negedge clk);
        rst_n = 1'b0;
        ref_half = 18.0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (1200) begin
            @(posedge clk);
            #1;
            if (lock) seen = 1'b1;
        end
        chk("fast_nolock", seen, 0);
        chk_rng("fast_ec", ec, 70, 72);
        chk("fast_lost", lost, 0);

        // 39ns refclk: within tolerance
        @(negedge clk);
        rst_n = 1'b0;
        ref_half = 19.5;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_lock(n, vh, l1, v1);
        chk("slow_lock_cyc", n, 777);
        chk_rng("slow_ec", ec, 65, 66);

        // select change while locked
        @(negedge clk);
        sel = 3'b010;
        wait_lock(n, vh, l1, v1);
        chk("sel_lock_next", l1, 0);
        chk("sel_vco_next", v1, 1);
        chk("sel_vco_hold", vh, 8);
        chk("sel_relock", n, 777);

        // select change exactly on a window-end cycle
        saved = ec;
        ref_en = 1'b0;
        repeat (255) @(posedge clk);
        @(negedge clk);
        sel = 3'b100;
        @(posedge clk);
        #1;
        chk("selwe_ec_kept", ec, saved);
        chk("selwe_lost", lost, 0);
        chk("selwe_lock", lock, 0);
        chk("selwe_vco", vco, 1);
        ref_en = 1'b1;
        wait_lock(n, vh, l1, v1);
        chk("selwe_vco_rest", vh, 7);
        chk("selwe_relock", n, 776);

        // power-down pulse mid-window
        repeat (100) @(posedge clk);
        @(negedge clk);
        pd = 1'b1;
        @(posedge clk);
        #1;
        chk("pd_lock", lock, 0);
        chk("pd_vco", vco, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        pd = 1'b0;
        wait_lock(n, vh, l1, v1);
        chk("pd_vco_hold", vh, 8);
        chk("pd_relock", n, 777);

        // lock-enable drop mid-window
        repeat (57) @(posedge clk);
        @(negedge clk);
        locken = 1'b0;
        @(posedge clk);
        #1;
        chk("len_lock", lock, 0);
        chk("len_vco", vco, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        locken = 1'b1;
        wait_lock(n, vh, l1, v1);
        chk("len_vco_hold", vh, 8);
        chk("len_relock", n, 777);

        // asynchronous reset between edges while locked
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lock", lock, 0);
        chk("arst_vco", vco, 0);
        chk("arst_ec", ec, 0);
        chk("arst_lost", lost, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_lock(n, vh, l1, v1);
        chk("arst_vco_hold", vh, 8);
        chk("arst_relock", n, 777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
